// File: rtl/rr_mux_channel.sv
// Arbitrated N:1 stream mux with a single registered output stage.
// Round-robin or fixed-priority grant, selectable per cycle via rr_mode.
module rr_mux_channel #(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 8,
   localparam int SEL_W   = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      rr_mode,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic                      out_valid,
   output logic [SEL_W-1:0]          out_sel,
   input  logic                      out_ready
);

   logic [WIDTH-1:0] chan_data [CHANNELS];
   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] grant;
   logic             grant_found;
   logic             load_en;
   int               scan_start;
   int               scan_idx;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_unpack
      assign chan_data[i] = in_data[i*WIDTH +: WIDTH];
   end

   assign load_en = !out_valid || out_ready;

   // Scan starts at ptr in round-robin mode, at channel 0 in fixed-priority mode.
   // NOTE: every always_comb output gets a default before any conditional
   // assignment, otherwise an unassigned path infers a latch.
   always_comb begin
      grant       = '0;
      grant_found = 1'b0;
      scan_start  = rr_mode ? int'(ptr) : 0;
      scan_idx    = 0;
      for (int k = 0; k < CHANNELS; k++) begin
         scan_idx = scan_start + k;
         if (scan_idx >= CHANNELS) scan_idx = scan_idx - CHANNELS;
         if (!grant_found && in_valid[scan_idx]) begin
            grant_found = 1'b1;
            grant       = SEL_W'(scan_idx);
         end
      end
   end

   always_comb begin
      in_ready = '0;
      if (reset_n && load_en && grant_found) in_ready[grant] = 1'b1;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_data  <= '0;
         out_sel   <= '0;
         out_valid <= 1'b0;
         ptr       <= '0;
      end else if (load_en) begin
         if (grant_found) begin
            out_data  <= chan_data[grant];
            out_sel   <= grant;
            out_valid <= 1'b1;
            if (rr_mode) ptr <= (grant == SEL_W'(CHANNELS - 1)) ? '0 : grant + 1'b1;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
